cp0_unit: RTL

- Coprocessor-0 at the M stage of the exception-capable MIPS pipeline.
- Consumes the exception, branch-delay, eret and mtc0 fields that the E→M pipeline register delivers, plus the six hardware interrupt lines.
- Keeps SR, Cause, EPC and PRId.
- Produces `req`, which flushes every pipeline register and redirects fetch to the handler. It also produces `EPC_out` for eret and `CP0_RD` for mfc0.

---
 rtl/cp0_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/cp0_unit.sv
// Coprocessor-0 at the M stage: holds SR/Cause/EPC/PRId, raises the exception or
// interrupt request and serves mfc0 reads plus the EPC value used by eret.
module cp0_unit #(
    parameter logic [31:0] PRID_VALUE = 32'h2023_0007,
    parameter bit          EPC_ALIGN  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] M_pc,
    input  logic        M_BD,
    input  logic [4:0]  M_ExcCode,
    input  logic        M_eret,
    input  logic        CP0_WE_M,
    input  logic [4:0]  M_CP0_addr,
    input  logic [31:0] CP0_WD,
    input  logic [5:0]  HWInt,
    output logic [31:0] CP0_RD,
    output logic [31:0] EPC_out,
    output logic        req
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] epc_raw;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    function automatic logic [31:0] align_epc(input logic [31:0] v);
        return EPC_ALIGN ? {v[31:2], 2'b00} : v;
    endfunction

    // Interrupts win over synchronous exceptions; EXL blocks both (no re-entry).
    always_comb begin
        int_req = ie_q & ~exl_q & (|(HWInt & im_q));
        exc_req = ~exl_q & (M_ExcCode != 5'd0);
    end

    assign req     = (int_req | exc_req) & ~reset;
    assign epc_raw = M_BD ? (M_pc - 32'd4) : M_pc;

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_d       = HWInt;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        if (req) begin
            exl_d      = 1'b1;
            exc_code_d = int_req ? 5'd0 : M_ExcCode;
            bd_d       = M_BD;
            epc_d      = align_epc(epc_raw);
        end else begin
            if (M_eret) begin
                exl_d = 1'b0;
            end
            // An mtc0 to SR is applied after eret, so its EXL bit has the last word.
            if (CP0_WE_M && (M_CP0_addr == ADDR_SR)) begin
                im_d  = CP0_WD[15:10];
                exl_d = CP0_WD[1];
                ie_d  = CP0_WD[0];
            end
            if (CP0_WE_M && (M_CP0_addr == ADDR_EPC)) begin
                epc_d = align_epc(CP0_WD);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= 6'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= 6'd0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    assign sr_word    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    assign cause_word = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};

    always_comb begin
        case (M_CP0_addr)
            ADDR_SR:    CP0_RD = sr_word;
            ADDR_CAUSE: CP0_RD = cause_word;
            ADDR_EPC:   CP0_RD = epc_q;
            ADDR_PRID:  CP0_RD = PRID_VALUE;
            default:    CP0_RD = 32'd0;
        endcase
    end

    assign EPC_out = epc_q;

endmodule
